// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned WIDTH_W = 2;

  typedef enum logic [WIDTH_W-1:0] {
    RAM_WIDTH8  = 2'd0,
    RAM_WIDTH16 = 2'd1,
    RAM_WIDTH32 = 2'd2,
    RAM_WIDTH64 = 2'd3
  } ram_width_e;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitReady = 2'd1,
    StWaitCpl   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);

  always_comb begin
    valid = |req;
    gnt   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one memory port, one transaction outstanding at a time.
// Optional completion timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_cpu,
  input  logic               rst_n,
  input  logic               c0_req,
  input  logic               c0_we,
  input  logic [ADDR_W-1:0]  c0_addr,
  input  logic [WIDTH_W-1:0] c0_width,
  input  logic [DATA_W-1:0]  c0_wdata,
  output logic               c0_done,
  output logic               c0_err,
  output logic [DATA_W-1:0]  c0_rdata,
  input  logic               c1_req,
  input  logic               c1_we,
  input  logic [ADDR_W-1:0]  c1_addr,
  input  logic [WIDTH_W-1:0] c1_width,
  input  logic [DATA_W-1:0]  c1_wdata,
  output logic               c1_done,
  output logic               c1_err,
  output logic [DATA_W-1:0]  c1_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WIDTH_W-1:0] mem_width,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_rstrobe,
  output logic               mem_wstrobe,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  input  logic               mem_complete,
  output logic               busy
);

  arb_state_e state_q;
  logic       sel_q;
  logic       last_q;
  logic       we_q;
  logic [1:0] req_vec;
  logic       arb_valid;
  logic       arb_gnt;
  logic       cpl_hit;
  logic       tmo_hit;
  logic       fin;

  // A requester whose done is high this cycle is not re-armed until the next idle cycle.
  assign req_vec = {c1_req & ~c1_done, c0_req & ~c0_done};

  rr_arb2 u_rr_arb2 (
    .req   (req_vec),
    .last  (last_q),
    .valid (arb_valid),
    .gnt   (arb_gnt)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q != StWaitCpl) begin
      cnt_q <= '0;
    end else if (!fin) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tmo_hit = (state_q == StWaitCpl) && !mem_complete &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  assign c0_err  = 1'b0;
  assign c1_err  = 1'b0;
`endif

  assign cpl_hit = (state_q == StWaitCpl) && mem_complete;
  assign fin     = cpl_hit | tmo_hit;
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_width   <= RAM_WIDTH8;
      mem_wdata   <= '0;
      mem_rstrobe <= 1'b0;
      mem_wstrobe <= 1'b0;
      c0_done     <= 1'b0;
      c1_done     <= 1'b0;
      c0_rdata    <= '0;
      c1_rdata    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      c0_err      <= 1'b0;
      c1_err      <= 1'b0;
`endif
    end else begin
      mem_rstrobe <= 1'b0;
      mem_wstrobe <= 1'b0;
      c0_done     <= 1'b0;
      c1_done     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      c0_err      <= 1'b0;
      c1_err      <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            sel_q     <= arb_gnt;
            we_q      <= arb_gnt ? c1_we    : c0_we;
            mem_addr  <= arb_gnt ? c1_addr  : c0_addr;
            mem_width <= arb_gnt ? c1_width : c0_width;
            mem_wdata <= arb_gnt ? c1_wdata : c0_wdata;
            state_q   <= StWaitReady;
          end
        end
        StWaitReady: begin
          if (mem_ready) begin
            mem_wstrobe <= we_q;
            mem_rstrobe <= ~we_q;
            state_q     <= StWaitCpl;
          end
        end
        StWaitCpl: begin
          if (fin) begin
            last_q  <= sel_q;
            state_q <= StIdle;
            if (sel_q) c1_done <= 1'b1;
            else       c0_done <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            if (sel_q) c1_err <= tmo_hit;
            else       c0_err <= tmo_hit;
`endif
            if (cpl_hit && !we_q) begin
              if (sel_q) c1_rdata <= mem_rdata;
              else       c0_rdata <= mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven and outputs sampled 1ns after
// each rising clk_cpu edge.
module tb_mem_port_arbiter;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [27:0] c0_addr, c1_addr;
  logic [1:0]  c0_width, c1_width;
  logic [63:0] c0_wdata, c1_wdata;
  logic        c0_done, c0_err, c1_done, c1_err;
  logic [63:0] c0_rdata, c1_rdata;
  logic [27:0] mem_addr;
  logic [1:0]  mem_width;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_rstrobe, mem_wstrobe, mem_ready, mem_complete, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_cpu = ~clk_cpu;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_cpu      (clk_cpu),
    .rst_n        (rst_n),
    .c0_req       (c0_req),
    .c0_we        (c0_we),
    .c0_addr      (c0_addr),
    .c0_width     (c0_width),
    .c0_wdata     (c0_wdata),
    .c0_done      (c0_done),
    .c0_err       (c0_err),
    .c0_rdata     (c0_rdata),
    .c1_req       (c1_req),
    .c1_we        (c1_we),
    .c1_addr      (c1_addr),
    .c1_width     (c1_width),
    .c1_wdata     (c1_wdata),
    .c1_done      (c1_done),
    .c1_err       (c1_err),
    .c1_rdata     (c1_rdata),
    .mem_addr     (mem_addr),
    .mem_width    (mem_width),
    .mem_wdata    (mem_wdata),
    .mem_rstrobe  (mem_rstrobe),
    .mem_wstrobe  (mem_wstrobe),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_complete (mem_complete),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_width = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_width = '0; c1_wdata = '0;
    mem_rdata = '0; mem_ready = 0; mem_complete = 0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({mem_rstrobe, mem_wstrobe}), 64'd0);
    chk("rst_done", 64'({c0_done, c1_done, c0_err, c1_err}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_c0_rdata", c0_rdata, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // c0 write, memory ready immediately
    mem_ready = 1;
    c0_req = 1; c0_we = 1; c0_addr = 28'h0000100; c0_width = 2'd3;
    c0_wdata = 64'hA5A5A5A55A5A5A5A;
    step();
    chk("wr_busy", 64'(busy), 64'd1);
    chk("wr_no_strobe_k1", 64'({mem_rstrobe, mem_wstrobe}), 64'd0);
    chk("wr_addr", 64'(mem_addr), 64'h100);
    step();
    chk("wr_strobe", 64'({mem_rstrobe, mem_wstrobe}), 64'b01);
    chk("wr_wdata", mem_wdata, 64'hA5A5A5A55A5A5A5A);
    chk("wr_width", 64'(mem_width), 64'd3);
    mem_complete = 1;
    step();
    chk("wr_strobe_one_cycle", 64'(mem_wstrobe), 64'd0);
    chk("wr_done", 64'({c0_done, c0_err, c1_done}), 64'b100);
    mem_complete = 0; c0_req = 0;
    step();
    chk("wr_done_pulse", 64'(c0_done), 64'd0);
    chk("wr_idle", 64'(busy), 64'd0);
    chk("wr_c0_rdata_kept", c0_rdata, 64'd0);

    // c1 read
    c1_req = 1; c1_we = 0; c1_addr = 28'h0ABCDEF; c1_width = 2'd2;
    mem_rdata = 64'h0123456789ABCDEF;
    step();
    step();
    chk("rd_strobe", 64'({mem_rstrobe, mem_wstrobe}), 64'b10);
    chk("rd_addr", 64'(mem_addr), 64'h0ABCDEF);
    mem_complete = 1;
    step();
    chk("rd_done", 64'({c1_done, c1_err, c0_done}), 64'b100);
    chk("rd_c1_rdata", c1_rdata, 64'h0123456789ABCDEF);
    chk("rd_c0_rdata_kept", c0_rdata, 64'd0);
    mem_complete = 0; c1_req = 0;
    step();

    // c0 read with memory stalled 20 cycles; completion during stall ignored; req dropped early
    mem_ready = 0;
    c0_req = 1; c0_we = 0; c0_addr = 28'h0000200; c0_width = 2'd1;
    step();
    c0_req = 0; mem_complete = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_no_strobe_or_done",
          64'({mem_rstrobe, mem_wstrobe, c0_done, c1_done}), 64'd0);
      chk("stall_addr", 64'(mem_addr), 64'h200);
    end
    mem_complete = 0; mem_ready = 1;
    step();
    chk("stall_strobe", 64'({mem_rstrobe, mem_wstrobe}), 64'b10);
    mem_ready = 0;
    step();
    chk("stall_strobe_once", 64'({mem_rstrobe, mem_wstrobe}), 64'd0);
    chk("stall_still_busy", 64'(busy), 64'd1);
    mem_rdata = 64'hDEADBEEF00001111; mem_complete = 1;
    step();
    chk("stall_done", 64'({c0_done, c1_done}), 64'b10);
    chk("stall_c0_rdata", c0_rdata, 64'hDEADBEEF00001111);
    chk("stall_c1_rdata_kept", c1_rdata, 64'h0123456789ABCDEF);
    mem_complete = 0;
    step();
    chk("complete_in_idle_ignored", 64'({busy, c0_done, c1_done}), 64'd0);

    // reset in WAIT_CPL; last grant was c0, so reset must restore c0 priority
    mem_ready = 1;
    c1_req = 1; c1_we = 1; c1_addr = 28'h0000300; c1_wdata = 64'h1;
    step(); step();
    chk("rstmid_strobe", 64'(mem_wstrobe), 64'd1);
    rst_n = 0;
    #1;
    chk("rstmid_strobes", 64'({mem_rstrobe, mem_wstrobe}), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_rdata", c0_rdata | c1_rdata, 64'd0);
    mem_complete = 1; c1_req = 0;
    step();
    rst_n = 1;
    step(); step();
    chk("rstmid_no_done", 64'({c0_done, c1_done, busy}), 64'd0);
    mem_complete = 0;

    // contention: grant order 0,1,0 with continuous requests
    mem_ready = 1; mem_complete = 1; mem_rdata = 64'h55;
    c0_req = 1; c0_we = 0; c0_addr = 28'h0000010;
    c1_req = 1; c1_we = 0; c1_addr = 28'h0000020;
    step();
    chk("rr_first_c0", 64'(mem_addr), 64'h10);
    step(); step();
    chk("rr_done0", 64'({c0_done, c1_done}), 64'b10);
    step();
    chk("rr_second_c1", 64'(mem_addr), 64'h20);
    step(); step();
    chk("rr_done1", 64'({c0_done, c1_done}), 64'b01);
    step();
    chk("rr_third_c0", 64'(mem_addr), 64'h10);
    step(); step();
    chk("rr_done2", 64'({c0_done, c1_done}), 64'b10);
    c0_req = 0; c1_req = 0;
    step();
    chk("rr_idle", 64'(busy), 64'd0);

    // req held through its own done is not re-granted in that cycle
    c0_req = 1; c0_addr = 28'h0000040;
    step(); step(); step();
    chk("rearm_done", 64'(c0_done), 64'd1);
    step();
    chk("rearm_masked", 64'(busy), 64'd0);
    step();
    chk("rearm_next_idle", 64'(busy), 64'd1);
    c0_req = 0;
    step(); step();
    chk("rearm_done2", 64'(c0_done), 64'd1);
    mem_complete = 0;
    step();

    // completion timeout behaviour
    mem_rdata = 64'h99;
    c0_req = 1; c0_addr = 28'h0000050;
    step(); step();
    c0_req = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      chk("tmo_waiting", 64'({c0_done, busy}), 64'b01);
    end
    step();
    chk("tmo_done_err", 64'({c0_done, c0_err}), 64'b11);
    chk("tmo_rdata_kept", c0_rdata, 64'h55);
    mem_complete = 1;
    step();
    chk("tmo_late_cpl_ignored", 64'({c0_done, c0_err, busy}), 64'd0);
    mem_complete = 0;
`else
    for (int i = 0; i < 100; i++) step();
    chk("notmo_waiting", 64'({c0_done, c0_err, busy}), 64'b001);
    mem_complete = 1;
    step();
    chk("notmo_done", 64'({c0_done, c0_err}), 64'b10);
    chk("notmo_rdata", c0_rdata, 64'h99);
    mem_complete = 0;
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
